// File: rtl/csa_accum_seq_if.sv
// Operand/result handshake bundle for csa_accum_seq.
// Latency: none (wires only).
// Backpressure: in_ready gates operands, out_ready gates the result.
interface csa_accum_seq_if #(
  parameter int W  = 8,
  parameter int SW = 16
);
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          in_ready;
  logic          out_valid;
  logic [SW-1:0] out_data;
  logic          out_ready;
  logic [7:0]    op_cnt;
  logic          busy;

  // Producer/consumer side driving operands and taking the result.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, op_cnt, busy
  );

  // Accumulator side.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, op_cnt, busy
  );
endinterface

// File: rtl/csa_accum_seq.sv
// Frame accumulator: carry-save sums NOPS unsigned operands, one carry-propagate add at frame end.
// Latency: result valid one edge after the final operand is accepted; min NOPS+2 cycles per frame.
// Backpressure: in_ready low while the result is resolved/held; result held until out_ready.
// Optional feature macro CSA_SEQ_LAST_EN: in_last terminates a frame early (NOPS stays the cap).
module csa_accum_seq #(
  parameter int W    = 8,
  parameter int NOPS = 10,
  parameter int SW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  csa_accum_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

  localparam logic [7:0] NOPS_C = 8'(NOPS);

  state_t        state_q, state_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [SW-1:0] car_q, car_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [SW-1:0] out_q, out_d;

  logic          in_rdy;
  logic          accept;
  logic          frame_end;
  logic [SW-1:0] op;
  logic [SW-1:0] cy;

  assign in_rdy = (state_q == IDLE) || (state_q == ACCUM);
  assign accept = bus.in_valid && in_rdy;
  assign op     = SW'(bus.in_data);
  // Carry vector is stored unshifted; its weight is applied when it is consumed.
  assign cy     = car_q << 1;

`ifdef CSA_SEQ_LAST_EN
  assign frame_end = (cnt_q + 8'd1 == NOPS_C) || bus.in_last;
`else
  assign frame_end = (cnt_q + 8'd1 == NOPS_C);
  logic unused_in_last;
  assign unused_in_last = bus.in_last;
`endif

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = out_q;
  assign bus.op_cnt    = cnt_q;
  assign bus.busy      = (state_q != IDLE);

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      car_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      car_q   <= car_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // Next-state and datapath update; clr overrides every other transition.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    car_d   = car_q;
    cnt_d   = cnt_q;
    out_d   = out_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          sum_d   = sum_q ^ cy ^ op;
          car_d   = (sum_q & cy) | (sum_q & op) | (cy & op);
          cnt_d   = cnt_q + 8'd1;
          state_d = frame_end ? RESOLVE : ACCUM;
        end
      end
      RESOLVE: begin
        out_d   = sum_q + (car_q << 1);
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          sum_d   = '0;
          car_d   = '0;
          cnt_d   = '0;
          out_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr) begin
      sum_d   = '0;
      car_d   = '0;
      cnt_d   = '0;
      out_d   = '0;
      state_d = IDLE;
    end
  end

endmodule

// File: tb/tb_csa_accum_seq.sv
// Directed bench for csa_accum_seq: frame table plus clr/reset/in_last sequences.
module tb_csa_accum_seq;

  localparam int W    = 8;
  localparam int NOPS = 10;
  localparam int SW   = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;

  csa_accum_seq_if #(.W(W), .SW(SW)) bus ();

  csa_accum_seq #(.W(W), .NOPS(NOPS), .SW(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ops [10];
    int          n;
    bit          gap;
    int          hold;
    int          last_idx;
    logic [15:0] exp;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed one frame, then follow it through RESOLVE and DONE to the handshake.
  task automatic run_frame(input vec_t v);
    bus.out_ready = (v.hold == 0);
    for (int i = 0; i < v.n; i++) begin
      if (v.gap && i > 0) begin
        bus.in_valid = 1'b0;
        tick();
        chk("stall_cnt", 32'(bus.op_cnt), i);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = v.ops[i];
      bus.in_last  = (i == v.last_idx);
      chk("in_ready_accum", 32'(bus.in_ready), 1);
      tick();
      chk("op_cnt", 32'(bus.op_cnt), i + 1);
    end
    // Operands offered while resolving/holding must be ignored.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd99;
    bus.in_last  = 1'b0;
    chk("resolve_valid", 32'(bus.out_valid), 0);
    chk("resolve_ready", 32'(bus.in_ready), 0);
    chk("resolve_data", 32'(bus.out_data), 0);
    tick();
    chk("done_valid", 32'(bus.out_valid), 1);
    chk("done_data", 32'(bus.out_data), 32'(v.exp));
    chk("done_cnt", 32'(bus.op_cnt), v.n);
    for (int k = 0; k < v.hold; k++) begin
      tick();
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_data", 32'(bus.out_data), 32'(v.exp));
      chk("hold_ready", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("post_valid", 32'(bus.out_valid), 0);
    chk("post_data", 32'(bus.out_data), 0);
    chk("post_cnt", 32'(bus.op_cnt), 0);
    chk("post_busy", 32'(bus.busy), 0);
  endtask

  vec_t tbl [5];
  vec_t v;

  initial begin
    tbl[0].ops = '{8'd11, 8'd2, 8'd13, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
    tbl[0].n = 10; tbl[0].gap = 1'b0; tbl[0].hold = 0; tbl[0].last_idx = -1; tbl[0].exp = 16'd75;
    tbl[1].ops = '{8'd3, 8'd14, 8'd5, 8'd6, 8'd7, 8'd8, 8'd19, 8'd10, 8'd0, 8'd0};
    tbl[1].n = 10; tbl[1].gap = 1'b1; tbl[1].hold = 5; tbl[1].last_idx = -1; tbl[1].exp = 16'd72;
    tbl[2].ops = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    tbl[2].n = 10; tbl[2].gap = 1'b0; tbl[2].hold = 0; tbl[2].last_idx = -1; tbl[2].exp = 16'd2550;
    tbl[3].ops = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0};
    tbl[3].n = 10; tbl[3].gap = 1'b1; tbl[3].hold = 1; tbl[3].last_idx = -1; tbl[3].exp = 16'd1275;
    tbl[4].ops = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
`ifdef CSA_SEQ_LAST_EN
    tbl[4].n = 3;
`else
    tbl[4].n = 10;
`endif
    tbl[4].gap = 1'b0; tbl[4].hold = 0; tbl[4].last_idx = 2; tbl[4].exp = 16'd6;

    rst_n        = 1'b0;
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.out_ready = 1'b1;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_data", 32'(bus.out_data), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_cnt", 32'(bus.op_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 1);

    // Table frames.
    for (int t = 0; t < 5; t++) run_frame(tbl[t]);

    // clr after 4 operands, asserted together with an offered operand.
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i + 20);
      tick();
    end
    chk("pre_clr_cnt", 32'(bus.op_cnt), 4);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_cnt", 32'(bus.op_cnt), 0);
    chk("clr_busy", 32'(bus.busy), 0);
    chk("clr_valid", 32'(bus.out_valid), 0);
    v.ops = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
    v.n = 10; v.gap = 1'b0; v.hold = 0; v.last_idx = -1; v.exp = 16'd55;
    run_frame(v);

    // clr while a result is held in DONE.
    v.hold = 3;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = v.ops[i];
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("clr_done_pre", 32'(bus.out_valid), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_done_valid", 32'(bus.out_valid), 0);
    chk("clr_done_data", 32'(bus.out_data), 0);
    chk("clr_done_cnt", 32'(bus.op_cnt), 0);
    bus.out_ready = 1'b1;

    // Reset mid-frame after 6 operands.
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'd50;
      tick();
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(bus.op_cnt), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_data", 32'(bus.out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("no_stale_valid", 32'(bus.out_valid), 0);
      chk("no_stale_busy", 32'(bus.busy), 0);
    end
    run_frame(tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csa_accum_seq.md
CSA_ACCUM_SEQ -- requirements
Module: csa_accum_seq

Interface
REQ-001 SHALL have parameter W, default 8, operand width in bits.
REQ-002 SHALL have parameter NOPS, default 10, operands per frame (2..255).
REQ-003 SHALL have parameter SW, default 16, result width; SW >= W + ceil(log2(NOPS)).
REQ-004 SHALL have one clock and an asynchronous active-low reset, named as below.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 clr  input  1  synchronous frame abort.
REQ-008 in_valid  input  1  operand offered.
REQ-009 in_data  input  W  operand, unsigned.
REQ-010 in_last  input  1  final operand of frame; used only with CSA_SEQ_LAST_EN.
REQ-011 in_ready  output  1  operand accepted when in_valid && in_ready.
REQ-012 out_valid  output  1  result available.
REQ-013 out_data  output  SW  frame sum.
REQ-014 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-015 op_cnt  output  8  operands accepted in current frame.
REQ-016 busy  output  1  high in any state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM, RESOLVE, DONE.
REQ-018 SHALL hold in_ready=1 in IDLE and ACCUM, 0 in RESOLVE and DONE.
REQ-019 On accept: sum_r <= sum_r ^ cy ^ op; car_r <= majority(sum_r, cy, op); cy = car_r<<1, op = zero-extended in_data; all SW bits wide, no carry propagation.
REQ-020 On accept: op_cnt increments; IDLE -> ACCUM on the first accept of a frame.
REQ-021 Accept with op_cnt+1 == NOPS: next state RESOLVE; no further accepts.
REQ-022 RESOLVE: one cycle; out_data <= sum_r + (car_r<<1), truncated to SW; next state DONE.
REQ-023 out_valid SHALL rise on the first rising edge after the edge that accepted the final operand; throughput one frame per NOPS+2 cycles minimum.
REQ-024 DONE: out_valid=1; out_data stable until out_valid && out_ready.
REQ-025 Out handshake: sum_r, car_r, op_cnt cleared, next state IDLE; in_valid during DONE ignored.
REQ-026 clr in any state: next state IDLE, sum_r/car_r/op_cnt/out_valid cleared; clr wins over simultaneous accept or out handshake.
REQ-027 in_valid low in ACCUM: state and accumulators held (stall, no timeout).
REQ-028 out_data SHALL be 0 outside DONE.

Reset
REQ-029 rst_n low: state IDLE, sum_r=0, car_r=0, op_cnt=0, out_data=0, out_valid=0, busy=0; in_ready=1 after release.
REQ-030 Reset mid-frame: partial sums discarded; no out_valid for that frame.

Configuration
REQ-031 Macro CSA_SEQ_LAST_EN defined: accept with in_last=1 terminates the frame early (-> RESOLVE) regardless of op_cnt; NOPS remains the hard upper bound.
REQ-032 CSA_SEQ_LAST_EN undefined: in_last ignored; frame length is always exactly NOPS.

Verification
REQ-033 NOPS=10, ops 11,2,13,4,5,6,7,8,9,10 back-to-back, out_ready=1 -> out_data=75, out_valid one cycle, 1 edge after 10th accept.
REQ-034 Ops 3,14,5,6,7,8,19,10,0,0, in_valid gaps every other cycle, out_ready low 5 cycles -> out_data=72 held stable, in_ready=0 throughout DONE.
REQ-035 Ten operands of 255 -> out_data=2550, no truncation at SW=16.
REQ-036 clr after 4 operands, then ops 1..10 -> out_data=55, op_cnt restarts at 1; rst_n low after 6 operands -> all outputs at reset values, no stale result.
REQ-037 With CSA_SEQ_LAST_EN: ops 1,2,3 with in_last on 3 -> out_data=6, op_cnt=3; without: same stimulus plus 7 more ops of 0 -> out_data=6 only after 10th accept.
